// File: rtl/thread_sched_pkg.sv
// Shared types for the thread scheduler: thread-state encoding seen on the
// thread-state memory read port.
package thread_sched_pkg;

    localparam int unsigned TS_W = 2;

    typedef enum logic [TS_W-1:0] {
        TS_NONE   = 2'd0,
        TS_WR_RDY = 2'd1,
        TS_RD_RDY = 2'd2,
        TS_BUSY   = 2'd3
    } ts_state_e;

endpackage

// File: rtl/thread_sched_if.sv
// Scheduler <-> fetch / thread-state memory signals. The scheduler is the master.
interface thread_sched_if
    import thread_sched_pkg::*;
#(
    parameter int unsigned N_THREADS = 16
);
    localparam int unsigned TN_W = $clog2(N_THREADS);

    logic            entry_pt_switch;
    logic [TN_W-1:0] ts_rd_num;
    ts_state_e       ts_rd;
    logic            NEXT_THREAD;
    logic            RELOAD;
    logic [TN_W-1:0] thread_num;
    logic [TN_W-1:0] thread_num_ahead;
    logic            thread_init;
    logic            idle;

    modport master (
        input  entry_pt_switch, ts_rd, NEXT_THREAD,
        output ts_rd_num, RELOAD, thread_num, thread_num_ahead, thread_init, idle
    );

    modport slave (
        output entry_pt_switch, ts_rd, NEXT_THREAD,
        input  ts_rd_num, RELOAD, thread_num, thread_num_ahead, thread_init, idle
    );

endinterface

// File: rtl/thread_sched_scan.sv
// Look-ahead scanner: walks the thread-state memory for a WR_RDY thread, holds it
// as the candidate and keeps re-reading it until it is taken or goes stale.
module thread_sched_scan
    import thread_sched_pkg::*;
#(
    parameter int unsigned TN_W = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            flush,
    input  logic            reload,
    input  logic            pending,
    input  logic [TN_W-1:0] thread_num,
    input  ts_state_e       ts_rd,
    output logic [TN_W-1:0] ts_rd_num,
    output logic [TN_W-1:0] thread_num_ahead,
    output logic            ahead_valid,
    output logic            stale_c
);

    logic [TN_W-1:0] rd_num_d;
    logic            rdy_c;
    logic            cand_c;

    assign rdy_c   = (ts_rd == TS_WR_RDY);
    // Only the read that actually addressed the held candidate may invalidate it
    assign stale_c = ahead_valid & (rd_num_d == thread_num_ahead) & ~rdy_c;
    assign cand_c  = ~ahead_valid & rdy_c & ((rd_num_d != thread_num) | pending);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ts_rd_num        <= '0;
            rd_num_d         <= '0;
            thread_num_ahead <= '0;
            ahead_valid      <= 1'b0;
        end else begin
            rd_num_d <= ts_rd_num;
            if (flush) begin
                ts_rd_num   <= '0;
                ahead_valid <= 1'b0;
            end else if (reload || stale_c) begin
                ts_rd_num   <= thread_num_ahead + TN_W'(1);
                ahead_valid <= 1'b0;
            end else if (cand_c) begin
                thread_num_ahead <= rd_num_d;
                ts_rd_num        <= rd_num_d;
                ahead_valid      <= 1'b1;
            end else if (!ahead_valid) begin
                ts_rd_num <= ts_rd_num + TN_W'(1);
            end
        end
    end

endmodule

// File: rtl/thread_sched.sv
// Thread scheduler ahead of instruction fetch: init sequencing, pending switch
// tracking and zero-delay RELOAD onto the look-ahead candidate.
module thread_sched
    import thread_sched_pkg::*;
#(
    parameter int unsigned N_THREADS = 16
) (
    input  logic          CLK,
    input  logic          RST,
    thread_sched_if.master bus
);

    localparam int unsigned TN_W = $clog2(N_THREADS);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]      state, state_nxt;
    logic [TN_W-1:0] thread_num, thread_num_nxt;
    logic            pending, pending_nxt;
    logic [TN_W-1:0] ts_rd_num;
    logic [TN_W-1:0] thread_num_ahead;
    logic            ahead_valid;
    logic            stale_c;
    logic            reload_c;
    logic            thread_init;

    assign thread_init = (state == ST_INIT);
    // entry_pt_switch wins over a simultaneous switch request
    assign reload_c = ahead_valid & ~thread_init & ~bus.entry_pt_switch & ~stale_c
                    & (bus.NEXT_THREAD | pending);

    thread_sched_scan #(.TN_W(TN_W)) u_scan (
        .CLK              (CLK),
        .RST              (RST),
        .flush            (thread_init | bus.entry_pt_switch),
        .reload           (reload_c),
        .pending          (pending),
        .thread_num       (thread_num),
        .ts_rd            (bus.ts_rd),
        .ts_rd_num        (ts_rd_num),
        .thread_num_ahead (thread_num_ahead),
        .ahead_valid      (ahead_valid),
        .stale_c          (stale_c)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= ST_INIT;
            thread_num <= '0;
            pending    <= 1'b0;
        end else begin
            state      <= state_nxt;
            thread_num <= thread_num_nxt;
            pending    <= pending_nxt;
        end
    end

    // During init thread_num doubles as the init counter
    always_comb begin
        state_nxt      = state;
        thread_num_nxt = thread_num;
        pending_nxt    = pending;
        if (bus.entry_pt_switch) begin
            state_nxt      = ST_INIT;
            thread_num_nxt = '0;
            pending_nxt    = 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (thread_num == TN_W'(N_THREADS - 1)) begin
                        state_nxt      = ST_RUN;
                        thread_num_nxt = '0;
                        pending_nxt    = 1'b1;
                    end else begin
                        thread_num_nxt = thread_num + TN_W'(1);
                    end
                end
                ST_RUN: begin
                    if (reload_c) begin
                        thread_num_nxt = thread_num_ahead;
                        pending_nxt    = 1'b0;
                    end else if (bus.NEXT_THREAD) begin
                        pending_nxt = 1'b1;
                    end
                end
                default: state_nxt = ST_INIT;
            endcase
        end
    end

    assign bus.ts_rd_num        = ts_rd_num;
    assign bus.RELOAD           = reload_c;
    assign bus.thread_num       = thread_num;
    assign bus.thread_num_ahead = thread_num_ahead;
    assign bus.thread_init      = thread_init;
    assign bus.idle             = pending & ~ahead_valid & ~thread_init;

endmodule

// File: tb/tb_thread_sched.sv
// Bench for thread_sched with 4 threads; models the thread-state memory with a
// 1-cycle read and scoreboards every RELOAD against the expected target thread.
module tb_thread_sched;
    import thread_sched_pkg::*;

    localparam int unsigned NT = 4;

    logic      CLK;
    logic      RST;
    ts_state_e ts_mem [NT];
    int        checks;
    int        errors;
    int        n_reload;
    int        exp_q [$];
    logic      prev_reload;

    thread_sched_if #(.N_THREADS(NT)) bus ();

    thread_sched #(.N_THREADS(NT)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) bus.ts_rd <= ts_mem[bus.ts_rd_num];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    // Stops on the cycle RELOAD is high (before the switching edge)
    task automatic wait_reload(input string tag, input int max_cyc);
        int found;
        found = 0;
        for (int i = 0; i < max_cyc && found == 0; i++) begin
            if (bus.RELOAD) found = 1;
            else step();
        end
        check(tag, found, 1);
    endtask

    task automatic set_all(input ts_state_e s);
        for (int i = 0; i < NT; i++) ts_mem[i] = s;
    endtask

    // Scoreboard side: every RELOAD must match the next queued target
    always @(negedge CLK) begin
        #4;
        if (!RST && bus.RELOAD) begin
            n_reload++;
            check("reload_queued", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("reload_target", bus.thread_num_ahead, exp_q.pop_front());
            check("reload_b2b", prev_reload, 0);
        end
        prev_reload = bus.RELOAD;
    end

    initial begin
        checks = 0; errors = 0; n_reload = 0; prev_reload = 1'b0;
        RST = 1'b1;
        bus.NEXT_THREAD = 1'b0;
        bus.entry_pt_switch = 1'b0;
        set_all(TS_BUSY);
        step(); step();
        check("rst_init", bus.thread_init, 1);
        check("rst_num", bus.thread_num, 0);
        check("rst_rd_num", bus.ts_rd_num, 0);
        check("rst_reload", bus.RELOAD, 0);
        check("rst_idle", bus.idle, 0);

        // 1/2: init sequence, then only thread 2 ready
        ts_mem[2] = TS_WR_RDY;
        exp_q.push_back(2);
        RST = 1'b0;
        #1;
        for (int i = 0; i < int'(NT); i++) begin
            check("init_active", bus.thread_init, 1);
            check("init_num", bus.thread_num, i);
            step();
        end
        check("init_done", bus.thread_init, 0);
        check("init_num0", bus.thread_num, 0);
        check("init_pending", bus.idle, 1);
        wait_reload("t2_reload", 6);
        step();
        check("t2_num", bus.thread_num, 2);
        check("t2_idle", bus.idle, 0);

        // 3: candidate held, NEXT_THREAD switches same cycle
        ts_mem[2] = TS_BUSY;
        ts_mem[1] = TS_WR_RDY;
        repeat (6) step();
        check("t3_ahead", bus.thread_num_ahead, 1);
        exp_q.push_back(1);
        bus.NEXT_THREAD = 1'b1;
        #1;
        check("t3_same_cycle", bus.RELOAD, 1);
        step();
        bus.NEXT_THREAD = 1'b0;
        check("t3_num", bus.thread_num, 1);

        // 4: nothing ready -> idle; thread 3 becomes ready
        set_all(TS_BUSY);
        repeat (3) step();
        bus.NEXT_THREAD = 1'b1;
        #1;
        check("t4_no_reload", bus.RELOAD, 0);
        step();
        bus.NEXT_THREAD = 1'b0;
        check("t4_idle", bus.idle, 1);
        repeat (3) step();
        check("t4_still_idle", bus.idle, 1);
        ts_mem[3] = TS_WR_RDY;
        exp_q.push_back(3);
        wait_reload("t4_reload", 6);
        check("t4_idle_drop", bus.idle, 0);
        step();
        check("t4_num", bus.thread_num, 3);

        // 5: held candidate 1 goes stale; NEXT_THREAD on the stale read must not reload it
        ts_mem[3] = TS_BUSY;
        ts_mem[1] = TS_WR_RDY;
        repeat (6) step();
        check("t5_ahead", bus.thread_num_ahead, 1);
        ts_mem[1] = TS_BUSY;
        ts_mem[2] = TS_WR_RDY;
        step();
        exp_q.push_back(2);
        bus.NEXT_THREAD = 1'b1;
        #1;
        check("t5_stale", bus.RELOAD, 0);
        step();
        bus.NEXT_THREAD = 1'b0;
        wait_reload("t5_reload", 7);
        step();
        check("t5_num", bus.thread_num, 2);

        // 6: entry_pt_switch with NEXT_THREAD overrides, init restarts
        set_all(TS_BUSY);
        ts_mem[0] = TS_WR_RDY;
        repeat (6) step();
        check("t6_ahead", bus.thread_num_ahead, 0);
        bus.entry_pt_switch = 1'b1;
        bus.NEXT_THREAD = 1'b1;
        #1;
        check("t6_no_reload", bus.RELOAD, 0);
        step();
        bus.entry_pt_switch = 1'b0;
        bus.NEXT_THREAD = 1'b0;
        for (int i = 0; i < int'(NT); i++) begin
            check("t6_init", bus.thread_init, 1);
            check("t6_init_num", bus.thread_num, i);
            step();
        end
        check("t6_init_done", bus.thread_init, 0);
        check("t6_pending", bus.idle, 1);
        exp_q.push_back(0);
        wait_reload("t6_reload", 6);
        step();
        check("t6_num", bus.thread_num, 0);

        // RST mid-init takes effect without a clock edge
        bus.entry_pt_switch = 1'b1;
        step();
        bus.entry_pt_switch = 1'b0;
        step(); step();
        check("t6_mid_init", bus.thread_num, 2);
        RST = 1'b1;
        #1;
        check("t6_rst_num", bus.thread_num, 0);
        check("t6_rst_init", bus.thread_init, 1);
        check("t6_rst_idle", bus.idle, 0);
        check("t6_rst_reload", bus.RELOAD, 0);
        step();
        RST = 1'b0;
        step();

        check("reload_count", n_reload, 5);
        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
